hcsr04_echo_emulator: RTL and testbench

Synthesizable responder model of an HC-SR04 ultrasonic module. It is the sensor-side counterpart to the measurement block.
- Accepts the trig pulse produced by the measurement block.
- Returns an echo pulse whose width encodes a programmed distance.
- Replaces the physical sensor for closed-loop FPGA bring-up and ILA-observed regression, looping trig/Echo on-chip.

---
 rtl/ultrasonic_emu_pkg.sv | 27 ++
 rtl/us_tick_gen.sv | 37 +++
 rtl/hcsr04_echo_emulator.sv | 230 +++++++++++++++++++++++
 tb/tb_hcsr04_echo_emulator.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ultrasonic_emu_pkg.sv
// ultrasonic_emu_pkg
// Shared definitions for the HC-SR04 echo emulator and its measurement
// counterpart: FSM state encoding, default timing constants (so both sides
// agree on range limits) and the jitter LFSR step function.
package ultrasonic_emu_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TRIG_HI = 3'd1,
    BURST   = 3'd2,
    ECHO    = 3'd3,
    HOLDOFF = 3'd4
  } emu_state_t;

  localparam int DEF_TRIG_MIN_US = 10;
  localparam int DEF_BURST_US    = 200;
  localparam int DEF_US_PER_CM   = 58;
  localparam int DEF_MAX_CM      = 400;
  localparam int DEF_TIMEOUT_US  = 38000;
  localparam int DEF_HOLDOFF_US  = 10000;

  // 16-bit Fibonacci LFSR step, taps 16,14,13,11.
  function automatic logic [15:0] lfsr16_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

endpackage

// File: rtl/us_tick_gen.sv
// us_tick_gen
// Restartable microsecond prescaler. Counts 0..CYC_PER_US-1 and flags the
// last cycle of each microsecond. A restart forces the count to 0 on the
// next cycle so a new state always begins on a microsecond boundary.
// Ports:
//   clk     in  system clock
//   rst     in  asynchronous reset, active-high
//   restart in  clear the prescaler (next cycle counts from 0)
//   tick    out high on the final cycle of each microsecond
module us_tick_gen #(
  parameter int CYC_PER_US = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int            CW   = (CYC_PER_US > 1) ? $clog2(CYC_PER_US) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYC_PER_US - 1);

  logic [CW-1:0] count;

  // Prescaler counter with restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (restart || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/hcsr04_echo_emulator.sv
// hcsr04_echo_emulator
// Sensor-side responder model of an HC-SR04. A valid trig pulse (at least
// TRIG_MIN_US high) is answered, after a BURST_US delay, by an echo pulse
// whose width encodes dist_cm, followed by a HOLDOFF_US dead time.
// Optional build macro ECHO_JITTER_EN adds 0..7 us of LFSR jitter per echo.
// Ports:
//   sys_clk50m     in  system clock
//   sys_rst        in  asynchronous reset, active-high
//   trig           in  trigger (asynchronous, synchronized here)
//   dist_cm        in  programmed distance, sampled when trig is accepted
//   echo           out emulated echo
//   busy           out high whenever not IDLE
//   meas_done      out one-cycle pulse on the cycle echo falls
//   err_short_trig out one-cycle pulse when trig was too short
module hcsr04_echo_emulator
  import ultrasonic_emu_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int TRIG_MIN_US = DEF_TRIG_MIN_US,
  parameter int BURST_US    = DEF_BURST_US,
  parameter int US_PER_CM   = DEF_US_PER_CM,
  parameter int MAX_CM      = DEF_MAX_CM,
  parameter int TIMEOUT_US  = DEF_TIMEOUT_US,
  parameter int HOLDOFF_US  = DEF_HOLDOFF_US,
  parameter int DIST_W      = 10
) (
  input  logic              sys_clk50m,
  input  logic              sys_rst,
  input  logic              trig,
  input  logic [DIST_W-1:0] dist_cm,
  output logic              echo,
  output logic              busy,
  output logic              meas_done,
  output logic              err_short_trig
);

  localparam int          CYC_PER_US = CLK_FREQ_HZ / 1000000;
  localparam logic [20:0] TRIG_MIN_C = 21'(TRIG_MIN_US);
  localparam logic [20:0] BURST_LAST = 21'(BURST_US - 1);
  localparam logic [20:0] HOLD_LAST  = 21'(HOLDOFF_US - 1);

  emu_state_t        state;
  emu_state_t        state_next;
  logic              trig_s1;
  logic              trig_s2;
  logic              trig_d;
  logic              trig_rise;
  logic              trig_fall;
  logic              tick;
  logic              restart;
  logic [20:0]       cnt;
  logic [DIST_W-1:0] dist_lat;
  logic [15:0]       width_us;
  logic [15:0]       width_base;
  logic              in_range;
  logic              trig_long;
  logic              accept;
  logic              burst_done;
  logic              echo_done;
  logic              hold_done;
  logic              echo_n;
  logic              busy_n;
  logic              meas_done_n;
  logic              err_n;

  // Two-flop synchronizer plus edge-detect register for trig.
  always_ff @(posedge sys_clk50m or posedge sys_rst) begin
    if (sys_rst) begin
      trig_s1 <= 1'b0;
      trig_s2 <= 1'b0;
      trig_d  <= 1'b0;
    end else begin
      trig_s1 <= trig;
      trig_s2 <= trig_s1;
      trig_d  <= trig_s2;
    end
  end

  assign trig_rise = trig_s2 & ~trig_d;
  assign trig_fall = ~trig_s2 & trig_d;

  us_tick_gen #(
    .CYC_PER_US(CYC_PER_US)
  ) u_tick (
    .clk    (sys_clk50m),
    .rst    (sys_rst),
    .restart(restart),
    .tick   (tick)
  );

  // Restart the prescaler and us counter on every state change.
  assign restart    = (state_next != state);
  // The tick landing on the fall cycle still counts toward trig length.
  assign trig_long  = ((cnt + {20'd0, tick}) >= TRIG_MIN_C);
  assign accept     = (state == TRIG_HI) && trig_fall && trig_long;
  assign burst_done = tick && (cnt == BURST_LAST);
  assign echo_done  = tick && (cnt == ({5'd0, width_us} - 21'd1));
  assign hold_done  = tick && (cnt == HOLD_LAST);
  assign in_range   = (dist_lat != '0) &&
                      ({{(32-DIST_W){1'b0}}, dist_lat} <= 32'(MAX_CM));
  assign width_base = in_range ? 16'({{(32-DIST_W){1'b0}}, dist_lat} * 32'(US_PER_CM))
                               : 16'(TIMEOUT_US);

  // FSM state register.
  always_ff @(posedge sys_clk50m or posedge sys_rst) begin
    if (sys_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (trig_rise) state_next = TRIG_HI;
        else           state_next = IDLE;
      end
      TRIG_HI: begin
        if (trig_fall) state_next = trig_long ? BURST : IDLE;
        else           state_next = TRIG_HI;
      end
      BURST: begin
        if (burst_done) state_next = ECHO;
        else            state_next = BURST;
      end
      ECHO: begin
        if (echo_done) state_next = HOLDOFF;
        else           state_next = ECHO;
      end
      HOLDOFF: begin
        if (hold_done) state_next = IDLE;
        else           state_next = HOLDOFF;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM output decode, taken from the next state so outputs can be registered.
  always_comb begin
    echo_n      = (state_next == ECHO);
    busy_n      = (state_next != IDLE);
    meas_done_n = (state == ECHO) && echo_done;
    err_n       = (state == TRIG_HI) && trig_fall && !trig_long;
  end

  // Registered outputs; reset clears echo asynchronously.
  always_ff @(posedge sys_clk50m or posedge sys_rst) begin
    if (sys_rst) begin
      echo           <= 1'b0;
      busy           <= 1'b0;
      meas_done      <= 1'b0;
      err_short_trig <= 1'b0;
    end else begin
      echo           <= echo_n;
      busy           <= busy_n;
      meas_done      <= meas_done_n;
      err_short_trig <= err_n;
    end
  end

  // Microsecond counter; saturates in TRIG_HI so a stuck trig cannot wrap.
  always_ff @(posedge sys_clk50m or posedge sys_rst) begin
    if (sys_rst) begin
      cnt <= '0;
    end else if (restart || (state == IDLE)) begin
      cnt <= '0;
    end else if (tick) begin
      if (state == TRIG_HI) begin
        if (cnt < TRIG_MIN_C) cnt <= cnt + 21'd1;
        else                  cnt <= cnt;
      end else begin
        cnt <= cnt + 21'd1;
      end
    end else begin
      cnt <= cnt;
    end
  end

  // Distance latch at trigger acceptance.
  always_ff @(posedge sys_clk50m or posedge sys_rst) begin
    if (sys_rst) begin
      dist_lat <= '0;
    end else if (accept) begin
      dist_lat <= dist_cm;
    end else begin
      dist_lat <= dist_lat;
    end
  end

`ifdef ECHO_JITTER_EN
  logic [15:0] lfsr;

  // Jitter LFSR, stepped once per accepted trigger.
  always_ff @(posedge sys_clk50m or posedge sys_rst) begin
    if (sys_rst) begin
      lfsr <= 16'hACE1;
    end else if (accept) begin
      lfsr <= lfsr16_step(lfsr);
    end else begin
      lfsr <= lfsr;
    end
  end

  // Echo width in us, computed during BURST from the latched distance plus jitter.
  always_ff @(posedge sys_clk50m or posedge sys_rst) begin
    if (sys_rst) begin
      width_us <= '0;
    end else if (state == BURST) begin
      width_us <= width_base + {13'd0, lfsr[2:0]};
    end else begin
      width_us <= width_us;
    end
  end
`else
  // Echo width in us, computed during BURST from the latched distance.
  always_ff @(posedge sys_clk50m or posedge sys_rst) begin
    if (sys_rst) begin
      width_us <= '0;
    end else if (state == BURST) begin
      width_us <= width_base;
    end else begin
      width_us <= width_us;
    end
  end
`endif

endmodule

// File: tb/tb_hcsr04_echo_emulator.sv
// tb_hcsr04_echo_emulator
// Directed bench for hcsr04_echo_emulator with scaled-down timing:
// 5 cycles/us, TRIG_MIN 10 us, BURST 20 us (100 cycles), 2 us/cm,
// MAX 400 cm, TIMEOUT 1000 us (5000 cycles), HOLDOFF 100 us (500 cycles).
module tb_hcsr04_echo_emulator;

  localparam int CYC = 5;

  logic       clk = 1'b0;
  logic       sys_rst;
  logic       trig;
  logic [9:0] dist_cm;
  logic       echo;
  logic       busy;
  logic       meas_done;
  logic       err_short_trig;

  int cyc     = 0;
  int echo_hi = 0;
  int md_cnt  = 0;
  int err_cnt = 0;
  int checks  = 0;
  int failures = 0;

  hcsr04_echo_emulator #(
    .CLK_FREQ_HZ(5000000),
    .TRIG_MIN_US(10),
    .BURST_US   (20),
    .US_PER_CM  (2),
    .MAX_CM     (400),
    .TIMEOUT_US (1000),
    .HOLDOFF_US (100),
    .DIST_W     (10)
  ) dut (
    .sys_clk50m    (clk),
    .sys_rst       (sys_rst),
    .trig          (trig),
    .dist_cm       (dist_cm),
    .echo          (echo),
    .busy          (busy),
    .meas_done     (meas_done),
    .err_short_trig(err_short_trig)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (echo === 1'b1)           echo_hi <= echo_hi + 1;
    if (meas_done === 1'b1)      md_cnt  <= md_cnt + 1;
    if (err_short_trig === 1'b1) err_cnt <= err_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_width(input string tag, input int w, input int exp_w);
`ifdef ECHO_JITTER_EN
    check(tag, 32'((w >= exp_w) && (w <= exp_w + 7 * CYC) && (w % CYC == 0)), 32'd1);
`else
    check(tag, w, exp_w);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_trig(input int hi, output int fall_at);
    trig = 1'b1;
    repeat (hi) step();
    trig = 1'b0;
    fall_at = cyc;
  endtask

  task automatic wait_echo(input logic v, input int bound, input string tag, output int at);
    int n = 0;
    while (echo !== v && n < bound) begin
      step();
      n++;
    end
    check(tag, echo, v);
    at = cyc;
  endtask

  task automatic wait_busy(input logic v, input int bound, input string tag, output int at);
    int n = 0;
    while (busy !== v && n < bound) begin
      step();
      n++;
    end
    check(tag, busy, v);
    at = cyc;
  endtask

  int f, r, e, b, m0, h0, e0, first_w;
  logic differ;
  int dist_tab [3] = '{0, 401, 400};
  int wid_tab  [3] = '{5000, 5000, 4000};

  initial begin
    sys_rst = 1'b1;
    trig    = 1'b0;
    dist_cm = 10'd0;
    differ  = 1'b0;
    first_w = 0;
    repeat (3) step();
    check("rst_echo", echo, 0);
    check("rst_busy", busy, 0);
    check("rst_meas_done", meas_done, 0);
    check("rst_err", err_short_trig, 0);
    sys_rst = 1'b0;
    repeat (5) step();
    check("idle_busy", busy, 0);

    // Nominal measurement at 100 cm.
    dist_cm = 10'd100;
    do_trig(60, f);
    wait_echo(1'b1, 300, "t1_rise_seen", r);
    check("t1_rise_latency", r - f, 103);
    m0 = md_cnt;
    wait_echo(1'b0, 10000, "t1_fall_seen", e);
    check_width("t1_width", e - r, 1000);
    check("t1_md_at_fall", meas_done, 1);
    step();
    check("t1_md_single", meas_done, 0);
    repeat (498) step();
    check("t1_busy_holdoff_end", busy, 1);
    step();
    check("t1_busy_idle", busy, 0);
    check("t1_md_count", md_cnt - m0, 1);

    // 5 us trig: too short.
    e0 = err_cnt;
    h0 = echo_hi;
    do_trig(25, f);
    repeat (2) step();
    check("t2_err_early", err_short_trig, 0);
    step();
    check("t2_err_pulse", err_short_trig, 1);
    step();
    check("t2_err_drop", err_short_trig, 0);
    check("t2_busy", busy, 0);
    repeat (200) step();
    check("t2_err_count", err_cnt - e0, 1);
    check("t2_no_echo", echo_hi - h0, 0);

    // 9 us trig: just under minimum.
    do_trig(45, f);
    repeat (3) step();
    check("t2b_err_pulse", err_short_trig, 1);
    repeat (200) step();
    check("t2b_no_echo", echo_hi - h0, 0);

    // Range limits: 0 cm and 401 cm time out, 400 cm is in range.
    for (int i = 0; i < 3; i++) begin
      dist_cm = 10'(dist_tab[i]);
      do_trig(60, f);
      wait_echo(1'b1, 300, "t3_rise_seen", r);
      wait_echo(1'b0, 6000, "t3_fall_seen", e);
      check_width($sformatf("t3_width_d%0d", dist_tab[i]), e - r, wid_tab[i]);
      wait_busy(1'b0, 600, "t3_idle", b);
    end

    // Triggers in ECHO and HOLDOFF are ignored; dist change has no effect.
    dist_cm = 10'd100;
    do_trig(60, f);
    wait_echo(1'b1, 300, "t4_rise_seen", r);
    repeat (300) step();
    dist_cm = 10'd5;
    do_trig(60, f);
    wait_echo(1'b0, 2000, "t4_fall_seen", e);
    check_width("t4_width", e - r, 1000);
    repeat (200) step();
    trig = 1'b1;
    wait_busy(1'b0, 1000, "t4_idle_seen", b);
    check("t4_holdoff_len", b - e, 500);
    repeat (100) step();
    check("t4_high_at_idle_ignored", busy, 0);
    trig = 1'b0;
    repeat (10) step();
    check("t4_fall_in_idle", busy, 0);
    dist_cm = 10'd3;
    do_trig(60, f);
    wait_echo(1'b1, 300, "t4b_rise_seen", r);
    wait_echo(1'b0, 500, "t4b_fall_seen", e);
    check_width("t4b_width", e - r, 30);
    wait_busy(1'b0, 600, "t4b_idle", b);

    // Reset in the middle of ECHO.
    dist_cm = 10'd100;
    do_trig(60, f);
    wait_echo(1'b1, 300, "t5_rise_seen", r);
    repeat (400) step();
    m0 = md_cnt;
    #2;
    sys_rst = 1'b1;
    #1;
    check("t5_echo_async", echo, 0);
    check("t5_busy_async", busy, 0);
    repeat (3) step();
    sys_rst = 1'b0;
    check("t5_no_md", md_cnt - m0, 0);
    repeat (3) step();
    dist_cm = 10'd1;
    do_trig(60, f);
    wait_echo(1'b1, 300, "t5b_rise_seen", r);
    check("t5b_rise_latency", r - f, 103);
    wait_echo(1'b0, 500, "t5b_fall_seen", e);
    check_width("t5b_width", e - r, 10);
    wait_busy(1'b0, 600, "t5b_idle", b);

    // Sixteen back-to-back measurements at 50 cm.
    dist_cm = 10'd50;
    for (int i = 0; i < 16; i++) begin
      do_trig(60, f);
      wait_echo(1'b1, 300, "t6_rise_seen", r);
      wait_echo(1'b0, 1000, "t6_fall_seen", e);
      check_width($sformatf("t6_width_%0d", i), e - r, 500);
      if (i == 0) first_w = e - r;
      else if ((e - r) != first_w) differ = 1'b1;
      wait_busy(1'b0, 600, "t6_idle", b);
    end
`ifdef ECHO_JITTER_EN
    check("t6_jitter_distinct", differ, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
